// File: rtl/pseudo_cpu_top.sv
// PseudoCPU: microcoded control (imem + pc) driving a two-register datapath.
// One instruction per clock, no pipeline; HALT freezes pc and registers until reset.

module pseudo_cpu_control (
  input  logic clk,
  input  logic rst,
  input  logic a_is_zero,
  output logic dec_a,
  output logic dec_b,
  output logic sub_ab,
  output logic swap_ab
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_DECA = 3'b001,
    OP_DECB = 3'b010,
    OP_SUB  = 3'b011,
    OP_SWAP = 3'b100,
    OP_JZ   = 3'b101,
    OP_JNZ  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  // Program store: preloaded externally, never written or cleared here.
  logic [7:0] imem [0:31];
  logic [4:0] addr;
  logic [4:0] addr_nxt;
  logic [7:0] instr;
  logic [4:0] t;
  op_t        op;

  assign instr = imem[addr];
  assign op    = op_t'(instr[7:5]);
  assign t     = instr[4:0];

  always_comb begin
    addr_nxt = addr + 5'd1;
    dec_a    = 1'b0;
    dec_b    = 1'b0;
    sub_ab   = 1'b0;
    swap_ab  = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_DECA: dec_a   = 1'b1;
      OP_DECB: dec_b   = 1'b1;
      OP_SUB:  sub_ab  = 1'b1;
      OP_SWAP: swap_ab = 1'b1;
      OP_JZ:   if (a_is_zero)  addr_nxt = t;
      OP_JNZ:  if (!a_is_zero) addr_nxt = t;
      OP_HALT: addr_nxt = addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr <= 5'd0;
    else      addr <= addr_nxt;
  end

endmodule

module pseudo_cpu_top (
  input  logic clk,
  input  logic rst
);

  logic [31:0] a;
  logic [31:0] b;
  logic        a_is_zero;
  logic        dec_a;
  logic        dec_b;
  logic        sub_ab;
  logic        swap_ab;

  // Zero test looks at the pre-edge a, so a branch right after SUB sees its result.
  assign a_is_zero = (a == 32'd0);

  pseudo_cpu_control control (
    .clk       (clk),
    .rst       (rst),
    .a_is_zero (a_is_zero),
    .dec_a     (dec_a),
    .dec_b     (dec_b),
    .sub_ab    (sub_ab),
    .swap_ab   (swap_ab)
  );

  // Registers hold unless strobed, so hierarchical deposits persist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= 32'd0;
      b <= 32'd0;
    end else begin
      if (dec_a)  a <= a - 32'd1;
      if (dec_b)  b <= b - 32'd1;
      if (sub_ab) a <= a - b;
      if (swap_ab) begin
        a <= b;
        b <= a;
      end
    end
  end

endmodule

// File: tb/tb_pseudo_cpu_top.sv
// Table-driven program runs for pseudo_cpu_top, checked through an expected-state scoreboard.

module tb_pseudo_cpu_top;

  logic clk;
  logic rst;

  pseudo_cpu_top dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] DECA = 8'h20;
  localparam logic [7:0] DECB = 8'h40;
  localparam logic [7:0] SUB  = 8'h60;
  localparam logic [7:0] SWAP = 8'h80;
  localparam logic [7:0] JZ4  = 8'hA4;
  localparam logic [7:0] JNZ0 = 8'hC0;
  localparam logic [7:0] HALT = 8'hE0;

  typedef struct {
    logic [0:7][7:0] prog;
    logic [7:0]      fill;
    logic [31:0]     a0;
    logic [31:0]     b0;
    int              cycles;
    logic [31:0]     ea;
    logic [31:0]     eb;
    logic [4:0]      eaddr;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
  } exp_t;

  localparam int NV = 11;
  vec_t tbl [NV];
  exp_t sb [$];
  int   total;
  int   bad;

  task automatic set_vec(input int k, input logic [63:0] p, input logic [7:0] f,
                         input logic [31:0] a0, input logic [31:0] b0, input int cyc,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] ead);
    tbl[k].prog   = p;
    tbl[k].fill   = f;
    tbl[k].a0     = a0;
    tbl[k].b0     = b0;
    tbl[k].cycles = cyc;
    tbl[k].ea     = ea;
    tbl[k].eb     = eb;
    tbl[k].eaddr  = ead;
  endtask

  task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] ead);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.addr = ead;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic check_pop(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    cmp({nm, ".a"}, dut.a, e.a);
    cmp({nm, ".b"}, dut.b, e.b);
    cmp({nm, ".addr"}, {27'd0, dut.control.addr}, {27'd0, e.addr});
  endtask

  // Reset, load program, release reset and deposit operands before the first edge.
  task automatic start_prog(input logic [0:7][7:0] p, input logic [7:0] f,
                            input logic [31:0] a0, input logic [31:0] b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) dut.control.imem[i] = (i < 8) ? p[i] : f;
    rst = 1'b1;
    dut.a = a0;
    dut.b = b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;

    set_vec(0,  {DECA, DECB, SUB, SWAP, HALT, HALT, HALT, HALT}, HALT, 32'd10, 32'd3, 5,
            32'd2, 32'd7, 5'd4);
    set_vec(1,  {DECA, DECB, SUB, SWAP, HALT, HALT, HALT, HALT}, HALT, 32'd10, 32'd3, 25,
            32'd2, 32'd7, 5'd4);
    set_vec(2,  {SUB, JZ4, NOP, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd4123481, 32'd4123481, 6,
            32'd0, 32'd4123481, 5'd4);
    set_vec(3,  {SUB, JZ4, NOP, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd4123481, 32'd9402102, 6,
            32'hFFAF7463, 32'd9402102, 5'd3);
    set_vec(4,  {DECA, JNZ0, HALT, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd7, 32'd5, 15,
            32'd0, 32'd5, 5'd2);
    set_vec(5,  {DECA, JNZ0, HALT, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd7, 32'd5, 3,
            32'd5, 32'd5, 5'd1);
    set_vec(6,  {DECA, HALT, HALT, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd0, 32'd1, 2,
            32'hFFFFFFFF, 32'd1, 5'd1);
    set_vec(7,  {DECB, HALT, HALT, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd6, 32'd0, 4,
            32'd6, 32'hFFFFFFFF, 5'd1);
    set_vec(8,  {NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP}, NOP, 32'd3, 32'd4, 31,
            32'd3, 32'd4, 5'd31);
    set_vec(9,  {NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP}, NOP, 32'd3, 32'd4, 33,
            32'd3, 32'd4, 5'd1);
    set_vec(10, {SWAP, SUB, JZ4, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd9, 32'd9, 5,
            32'd0, 32'd9, 5'd4);

    // Reset state, with clock edges arriving while reset is held.
    #1;
    push_exp(32'd0, 32'd0, 5'd0);
    check_pop("reset_init");
    repeat (2) @(negedge clk);
    push_exp(32'd0, 32'd0, 5'd0);
    check_pop("reset_held");

    for (int k = 0; k < NV; k++) begin
      start_prog(tbl[k].prog, tbl[k].fill, tbl[k].a0, tbl[k].b0);
      push_exp(tbl[k].ea, tbl[k].eb, tbl[k].eaddr);
      repeat (tbl[k].cycles) @(negedge clk);
      check_pop($sformatf("vec%0d", k));
    end

    // Deposits made during NOPs persist until the first writing instruction.
    start_prog({NOP, NOP, NOP, DECA, HALT, HALT, HALT, HALT}, HALT, 32'd1, 32'd2);
    @(negedge clk);
    #1;
    dut.a = 32'd4123481;
    dut.b = 32'd9402102;
    push_exp(32'd4123481, 32'd9402102, 5'd2);
    @(negedge clk);
    check_pop("persist_nop");
    push_exp(32'd4123480, 32'd9402102, 5'd4);
    repeat (3) @(negedge clk);
    check_pop("persist_deca");

    // Asynchronous reset in the middle of a countdown, away from any clock edge.
    start_prog({DECA, JNZ0, HALT, HALT, HALT, HALT, HALT, HALT}, HALT, 32'd100, 32'd77);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push_exp(32'd0, 32'd0, 5'd0);
    check_pop("async_rst");
    cmp("imem0_kept", {24'd0, dut.control.imem[0]}, {24'd0, DECA});
    cmp("imem1_kept", {24'd0, dut.control.imem[1]}, {24'd0, JNZ0});
    repeat (2) @(negedge clk);
    push_exp(32'd0, 32'd0, 5'd0);
    check_pop("async_rst_held");
    rst = 1'b1;
    dut.a = 32'd2;
    push_exp(32'd0, 32'd0, 5'd2);
    repeat (6) @(negedge clk);
    check_pop("restart_after_rst");

    cmp("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
